// File: rtl/serial_div_pkg.sv
// Shared definitions for the serial divisibility scheduler: FSM state type,
// residue width helper and the legal parameter ranges.
package serial_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int MIN_N_REQ   = 2;
    localparam int MAX_N_REQ   = 8;
    localparam int MIN_WIDTH   = 2;
    localparam int MAX_WIDTH   = 32;
    localparam int MIN_DIVISOR = 2;
    localparam int MAX_DIVISOR = 16;

    // Number of bits needed to hold a residue modulo d (at least one).
    function automatic int rw_of(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/serial_mod_residue.sv
// Generic serial modulo-DIVISOR step engine. Each enabled cycle folds one
// more operand bit (MSB first) into the running residue: r <= (2r + b) mod D.
// Because r < D, the value {r, b} is always below 2D, so a single
// conditional subtract replaces any multiply or divide.
module serial_mod_residue
    import serial_div_pkg::*;
#(
    parameter  int DIVISOR = 3,
    localparam int RW      = rw_of(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic          new_bit,
    output logic [RW-1:0] residue
);

    localparam logic [RW:0] D_VAL = (RW + 1)'(DIVISOR);

    logic [RW-1:0] residue_q;
    logic [RW-1:0] residue_d;
    logic [RW:0]   step_t;
    logic [RW:0]   step_diff;

    // Next residue: clear wins, otherwise one conditional-subtract step.
    always_comb begin
        step_t    = {residue_q, new_bit};
        step_diff = step_t - D_VAL;
        residue_d = residue_q;
        if (clear) begin
            residue_d = '0;
        end else if (en) begin
            residue_d = (step_t >= D_VAL) ? step_diff[RW-1:0] : step_t[RW-1:0];
        end
    end

    // Residue register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            residue_q <= '0;
        end else begin
            residue_q <= residue_d;
        end
    end

    assign residue = residue_q;

endmodule

// File: rtl/serial_divisibility_scheduler.sv
// Round-robin sequencer sharing one serial mod-DIVISOR residue engine among
// N_REQ requesters. A granted operand is shifted MSB-first through the engine
// one bit per clock, then a divisibility verdict tagged with the requester
// index is offered on a valid/ready result port.
// Optional feature macro: SERIAL_DIV_RESIDUE_OUT_EN adds the res_residue port.
module serial_divisibility_scheduler
    import serial_div_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = 8,
    parameter  int DIVISOR = 3,
    localparam int RW      = rw_of(DIVISOR),
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IW-1:0]          res_id,
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
    output logic                   res_div,
    output logic [RW-1:0]          res_residue
`else
    output logic                   res_div
`endif
);

    localparam int CW = $clog2(WIDTH);

    if (N_REQ < MIN_N_REQ || N_REQ > MAX_N_REQ ||
        WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH ||
        DIVISOR < MIN_DIVISOR || DIVISOR > MAX_DIVISOR) begin : g_bad_params
        $error("serial_divisibility_scheduler: parameter out of range");
    end

    state_e           state_q,     state_d;
    logic [IW-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [IW-1:0]    res_id_q,    res_id_d;
    logic             res_valid_q, res_valid_d;

    logic [N_REQ-1:0] grant_oh;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    logic [RW-1:0]    residue;
    logic             engine_en;

    // Round-robin arbiter: first valid requester at or after rr_ptr, only in IDLE.
    always_comb begin
        int probe;
        probe     = 0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (state_q == IDLE && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                probe = (int'(rr_ptr_q) + k) % N_REQ;
                if (!grant_any && req_valid[probe]) begin
                    grant_any = 1'b1;
                    grant_idx = IW'(probe);
                end
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    shreg_d   = req_data[int'(grant_idx)*WIDTH +: WIDTH];
                    res_id_d  = grant_idx;
                    bit_cnt_d = CW'(WIDTH - 1);
                    rr_ptr_d  = IW'((int'(grant_idx) + 1) % N_REQ);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - CW'(1);
                if (bit_cnt_q == '0) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset drops any in-flight operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign engine_en = (state_q == SHIFT);

    serial_mod_residue #(
        .DIVISOR (DIVISOR)
    ) u_residue (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_any),
        .en      (engine_en),
        .new_bit (shreg_q[WIDTH-1]),
        .residue (residue)
    );

    assign req_ready = grant_oh;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_div   = res_valid_q && (residue == '0);
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
    assign res_residue = residue;
`endif

endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// Self-checking bench for serial_divisibility_scheduler. A DIVISOR=3 instance
// exercises arbitration, latency, backpressure and reset; a DIVISOR=5 instance
// covers the second modulus. Expected values come from plain modulo arithmetic
// and a round-robin pointer model.
module tb_serial_divisibility_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int D   = 3;
    localparam int IW  = 2;
    localparam int RW  = 2;
    localparam int N5  = 2;
    localparam int D5  = 5;
    localparam int RW5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready;
    logic [IW-1:0]   res_id;
    logic            res_div;
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
    logic [RW-1:0]   res_residue;
    logic [RW5-1:0]  res_residue5;
`endif

    logic [N5-1:0]   req_valid5;
    logic [N5*W-1:0] req_data5;
    logic [N5-1:0]   req_ready5;
    logic            res_valid5;
    logic            res_ready5;
    logic [0:0]      res_id5;
    logic            res_div5;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    serial_divisibility_scheduler #(.N_REQ(N), .WIDTH(W), .DIVISOR(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
        .res_div     (res_div),
        .res_residue (res_residue)
`else
        .res_div     (res_div)
`endif
    );

    serial_divisibility_scheduler #(.N_REQ(N5), .WIDTH(W), .DIVISOR(D5)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid5),
        .req_data    (req_data5),
        .req_ready   (req_ready5),
        .res_valid   (res_valid5),
        .res_ready   (res_ready5),
        .res_id      (res_id5),
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
        .res_div     (res_div5),
        .res_residue (res_residue5)
`else
        .res_div     (res_div5)
`endif
    );

    // Round-robin reference: first set bit of mask at or after ptr, wrapping.
    function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Waits (bounded) for res_valid on the DIVISOR=3 instance; lat=-1 on timeout.
    task automatic wait_res3(output int lat, output int busy);
        lat  = -1;
        busy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) busy++;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '1; req_valid5 = '1; res_ready = 1'b1; res_ready5 = 1'b1;
        req_data = '0; req_data5 = '0;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0); end
        checks++; if (req_ready5 !== '0) begin errors++; $display("[TB] FAIL reset_req_ready5: got %b expected %b", req_ready5, 2'b0); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_id !== '0) begin errors++; $display("[TB] FAIL reset_res_id: got %0d expected 0", res_id); end
        checks++; if (res_div !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_div: got %b expected 0", res_div); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = '0; req_valid5 = '0;
        #1;
        checks++; if (res_valid !== 1'b0 || req_ready !== '0) begin errors++; $display("[TB] FAIL post_reset_idle: got valid=%b ready=%b expected 0/0000", res_valid, req_ready); end
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL post_reset_ptr: got %b expected 0001", req_ready); end
        req_valid = '0;
        model_ptr = 0;
    endtask

    task automatic test_single(input int idx, input int unsigned data, input string name);
        int lat, busy;
        logic [N-1:0] mask;
        int g;
        @(negedge clk);
        mask = onehot(idx);
        req_valid = mask;
        req_data[idx*W +: W] = W'(data);
        #1;
        g = model_grant(mask, model_ptr);
        checks++; if (req_ready !== onehot(g)) begin errors++; $display("[TB] FAIL %s_grant: got %b expected %b", name, req_ready, onehot(g)); end
        @(posedge clk);
        model_ptr = (g + 1) % N;
        #1 req_valid = '0;
        wait_res3(lat, busy);
        checks++; if (lat != W + 1) begin errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, W + 1); end
        checks++; if (busy != 0) begin errors++; $display("[TB] FAIL %s_ready_while_busy: got %0d expected 0", name, busy); end
        checks++; if (res_id !== IW'(g)) begin errors++; $display("[TB] FAIL %s_id: got %0d expected %0d", name, res_id, g); end
        checks++; if (res_div !== ((data % D) == 0)) begin errors++; $display("[TB] FAIL %s_div: got %b expected %b", name, res_div, (data % D) == 0); end
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
        checks++; if (res_residue !== RW'(data % D)) begin errors++; $display("[TB] FAIL %s_residue: got %0d expected %0d", name, res_residue, data % D); end
`endif
        @(posedge clk);
    endtask

    task automatic test_random();
        int unsigned dval [N];
        logic [N-1:0] mask;
        int g, lat, busy;
        for (int it = 0; it < 16; it++) begin
            @(negedge clk);
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                dval[i] = $urandom_range(0, 255);
                req_data[i*W +: W] = W'(dval[i]);
            end
            req_valid = mask;
            #1;
            g = model_grant(mask, model_ptr);
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", it, req_ready, onehot(g)); end
            @(posedge clk);
            model_ptr = (g + 1) % N;
            #1 req_valid = '0;
            wait_res3(lat, busy);
            checks++; if (lat != W + 1) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, W + 1); end
            checks++; if (res_id !== IW'(g)) begin errors++; $display("[TB] FAIL rand_id[%0d]: got %0d expected %0d", it, res_id, g); end
            checks++; if (res_div !== ((dval[g] % D) == 0)) begin errors++; $display("[TB] FAIL rand_div[%0d]: data %0d got %b expected %b", it, dval[g], res_div, (dval[g] % D) == 0); end
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
            checks++; if (res_residue !== RW'(dval[g] % D)) begin errors++; $display("[TB] FAIL rand_residue[%0d]: got %0d expected %0d", it, res_residue, dval[g] % D); end
`endif
            @(posedge clk);
        end
    endtask

    task automatic test_round_robin();
        int gcyc [5];
        int gid  [5];
        int grants, cyc, lat, busy, g;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom_range(0, 255));
        req_valid = '1;
        res_ready = 1'b1;
        grants = 0;
        cyc = 0;
        for (int k = 0; k < 80; k++) begin
            #1;
            if (req_ready != '0) begin
                gcyc[grants] = cyc;
                gid[grants] = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) gid[grants] = i;
                grants++;
                if (grants == 5) break;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (grants != 5) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 5", grants); end
        for (int k = 0; k < grants; k++) begin
            g = model_grant('1, model_ptr);
            model_ptr = (g + 1) % N;
            checks++; if (gid[k] != g) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", k, gid[k], g); end
            if (k > 0) begin
                checks++; if (gcyc[k] - gcyc[k-1] != W + 2) begin errors++; $display("[TB] FAIL rr_interval[%0d]: got %0d expected %0d", k, gcyc[k] - gcyc[k-1], W + 2); end
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_res3(lat, busy);
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] mask;
        int g1, g2, lat, busy;
        logic exp_div;
        int unsigned d1, d2;
        @(negedge clk);
        mask = 4'b0110;
        d1 = $urandom_range(0, 255);
        d2 = $urandom_range(0, 255);
        req_data[1*W +: W] = W'(d1);
        req_data[2*W +: W] = W'(d2);
        req_valid = mask;
        res_ready = 1'b0;
        #1;
        g1 = model_grant(mask, model_ptr);
        checks++; if (req_ready !== onehot(g1)) begin errors++; $display("[TB] FAIL bp_first_grant: got %b expected %b", req_ready, onehot(g1)); end
        @(posedge clk);
        model_ptr = (g1 + 1) % N;
        #1;
        req_valid[g1] = 1'b0;
        mask[g1] = 1'b0;
        wait_res3(lat, busy);
        exp_div = (((g1 == 1) ? d1 : d2) % D) == 0;
        checks++; if (lat != W + 1) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, W + 1); end
        checks++; if (busy != 0) begin errors++; $display("[TB] FAIL bp_ready_while_busy: got %0d expected 0", busy); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (res_valid !== 1'b1 || res_id !== IW'(g1) || res_div !== exp_div || req_ready !== '0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b id=%0d div=%b ready=%b expected 1/%0d/%b/0000", c, res_valid, res_id, res_div, req_ready, g1, exp_div);
            end
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL bp_handshake_no_grant: got %b expected 0000", req_ready); end
        @(posedge clk);
        @(negedge clk);
        #1;
        g2 = model_grant(mask, model_ptr);
        checks++; if (req_ready !== onehot(g2) || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_grant: got ready=%b valid=%b expected %b/0", req_ready, res_valid, onehot(g2)); end
        @(posedge clk);
        model_ptr = (g2 + 1) % N;
        #1 req_valid = '0;
        wait_res3(lat, busy);
        checks++; if (res_id !== IW'(g2)) begin errors++; $display("[TB] FAIL bp_second_id: got %0d expected %0d", res_id, g2); end
        @(posedge clk);
    endtask

    task automatic test_mid_reset();
        int seen;
        @(negedge clk);
        req_valid = 4'b0010;
        req_data[1*W +: W] = W'($urandom_range(0, 255));
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", res_valid); end
        checks++; if (req_ready !== onehot(model_grant(4'b1001, 0))) begin errors++; $display("[TB] FAIL midrst_ptr_both: got %b expected 0001", req_ready); end
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== onehot(model_grant(4'b1000, 0))) begin errors++; $display("[TB] FAIL midrst_ptr_alone: got %b expected 1000", req_ready); end
        req_valid = '0;
        model_ptr = 0;
        seen = 0;
        repeat (W + 3) begin
            @(negedge clk);
            #1;
            if (res_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midrst_dropped: got %0d result cycles expected 0", seen); end
    endtask

    task automatic test_divisor5();
        int unsigned vals [8];
        int lat;
        vals[0] = 255; vals[1] = 0; vals[2] = 254;
        for (int i = 3; i < 8; i++) vals[i] = $urandom_range(0, 255);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid5 = 2'b01;
            req_data5 = {W'(0), W'(vals[i])};
            #1;
            checks++; if (req_ready5 !== 2'b01) begin errors++; $display("[TB] FAIL d5_grant[%0d]: got %b expected 01", i, req_ready5); end
            @(posedge clk);
            #1 req_valid5 = '0;
            lat = -1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                #1;
                if (res_valid5) begin
                    lat = k;
                    break;
                end
            end
            checks++; if (lat != W + 1) begin errors++; $display("[TB] FAIL d5_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
            checks++; if (res_div5 !== ((vals[i] % D5) == 0)) begin errors++; $display("[TB] FAIL d5_div[%0d]: data %0d got %b expected %b", i, vals[i], res_div5, (vals[i] % D5) == 0); end
`ifdef SERIAL_DIV_RESIDUE_OUT_EN
            checks++; if (res_residue5 !== RW5'(vals[i] % D5)) begin errors++; $display("[TB] FAIL d5_residue[%0d]: got %0d expected %0d", i, res_residue5, vals[i] % D5); end
`endif
            @(posedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_data = '0; res_ready = 1'b1;
        req_valid5 = '0; req_data5 = '0; res_ready5 = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_single(0, 21, "div3_21");
        test_single(2, 22, "div3_22");
        test_single(1, 0, "div3_zero");
        test_random();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_divisor5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_divisibility_scheduler.md
# serial_divisibility_scheduler

Shares one serial modulo-DIVISOR residue engine among N_REQ requesters. Each requester offers a WIDTH-bit number over a valid/ready handshake. A round-robin arbiter grants one request at a time. The block shifts the granted number MSB-first through the residue engine, one bit per clock, then presents a divisibility verdict tagged with the requester index on a valid/ready result port. It sits in front of the serial divisibility FSMs as their sequencer and sharing point.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits (2..32)
- DIVISOR, 3, modulus (2..16); RW = $clog2(DIVISOR) residue bits
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req_valid  input  N_REQ  request i has an operand pending
- req_data  input  N_REQ*WIDTH  operand i in slice [i*WIDTH +: WIDTH]; stable while req_valid[i] is high
- req_ready  output  N_REQ  one-hot grant; operand i is accepted in the cycle where valid[i] and ready[i] are both high
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_id  output  $clog2(N_REQ)  index of the requester whose result this is
- res_div  output  1  1 when the operand mod DIVISOR == 0
- res_residue  output  RW  operand mod DIVISOR; present only with SERIAL_DIV_RESIDUE_OUT_EN

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first valid index at or after rr_ptr, wrapping modulo N_REQ.
  - req_ready is all-zero when no request is valid.
  - On grant: latch the operand into the shift register, latch the index into res_id, clear the residue, set bit_cnt = WIDTH-1, then go to SHIFT.
  - On grant: rr_ptr = (granted index + 1) mod N_REQ.
- SHIFT:
  - Each cycle, new_bit = shreg[WIDTH-1]; residue updates to (2*r + new_bit) mod D; shreg shifts left by 1; bit_cnt decrements.
  - After the cycle with bit_cnt == 0, go to DONE.
  - req_ready is 0.
- Residue arithmetic:
  - t = {r, new_bit} is RW+1 bits wide, so t < 2D.
  - Next residue = (t >= D) ? t - D : t.
  - No wider multiply or divide.
- DONE:
  - res_valid = 1; res_div = (residue == 0).
  - res_id and residue are held stable until the handshake.
  - On res_ready, go to IDLE. No grant is issued in that cycle; the next grant is possible in the following IDLE cycle.
- req_ready is 0 in SHIFT and DONE. Requests never queue inside the block.
- Operand 0 gives residue 0 and res_div = 1.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, res_valid = 0, req_ready = 0 during the reset cycle, res_id = 0, res_div = 0, residue = 0.
- Request accepted at cycle T. SHIFT occupies T+1..T+WIDTH. res_valid rises at T+WIDTH+1.
- Minimum issue interval is WIDTH+2 cycles with res_ready held high.
- Backpressure: res_valid and all result fields hold indefinitely while res_ready = 0.
- rst in any state, including mid-SHIFT or DONE:
  - The in-flight operand is dropped.
  - The next cycle is IDLE with rr_ptr = 0 and res_valid = 0.
- A requester that drops req_valid without a grant is simply skipped. No state is kept for it.

## Configuration
- SERIAL_DIV_RESIDUE_OUT_EN defined: the res_residue port exists and carries the final residue, valid with res_valid.
- Not defined: the port is absent. Only res_div is produced from the residue, and the rest of the behaviour is identical.

## Structure
- Package serial_div_pkg holds:
  - the state enum typedef (IDLE/SHIFT/DONE);
  - the RW width helper function;
  - parameter-legality constants (min/max of N_REQ, WIDTH, DIVISOR).
- Sub-module serial_mod_residue #(DIVISOR):
  - ports: clk, rst, clear, en, new_bit, residue[RW];
  - it is the generic mod-D step engine.
- The scheduler instantiates serial_mod_residue once, together with the arbiter, shift register and bit counter.

## Test plan
- DIVISOR=3, WIDTH=8: req_valid=4'b0001, data 8'd21 at cycle T:
  - req_ready=4'b0001 at T;
  - res_valid at T+9 with res_id=0, res_div=1, residue 0.
- Same configuration, data 8'd22 on requester 2: res_id=2, res_div=0, residue 1.
- All four requesters valid continuously, res_ready=1:
  - grants in order 0,1,2,3,0;
  - consecutive grants exactly 10 cycles apart.
- res_ready held 0 for 5 cycles after res_valid: outputs stable, req_ready=0, and the grant follows the cycle after the handshake.
- rst asserted at T+4 mid-SHIFT: res_valid=0 and state IDLE next cycle; requester 3 is then granted before requester 0 only if it alone is valid, because rr_ptr=0.
- DIVISOR=5: 8'd255 gives res_div=1; 8'd0 gives res_div=1; 8'd254 gives res_div=0, residue 4.
